// File: rtl/axis_uart_rx_os.sv
// Oversampling UART receiver with an AXI-Stream master output.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around mid-bit.
module axis_uart_rx_os #(
    parameter int DATA_WIDTH    = 8,
    parameter int DIVIDER_WIDTH = 32,
    parameter int OVERSAMPLE    = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [DIVIDER_WIDTH-1:0] clk_divider_i,
    input  logic [3:0]               data_bits_i,
    input  logic                     parity_odd_i,
    input  logic                     parity_even_i,
    input  logic                     two_stop_i,
    input  logic                     uart_rx_i,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata_o,
    output logic                     m_axis_tvalid_o,
    input  logic                     m_axis_tready_i,
    output logic                     parity_err_o,
    output logic                     frame_err_o,
    output logic                     overrun_o
);
    localparam int OSW      = $clog2(OVERSAMPLE);
    localparam int OS_LAST  = OVERSAMPLE - 1;
    localparam int OS_MID   = OVERSAMPLE / 2;
    localparam int OS_PRE   = OVERSAMPLE / 2 - 1;
    localparam int OS_POST  = OVERSAMPLE / 2 + 1;
    localparam logic [3:0] NB_MAX = DATA_WIDTH[3:0];

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_WAIT   = 3'd5;

    logic                     r_rx_s1;
    logic                     r_rx_s2;
    logic                     r_rx_prev;
    logic [DIVIDER_WIDTH-1:0] r_div_cnt;
    logic [OSW-1:0]           r_os_cnt;
    logic [2:0]               r_state;
    logic [3:0]               r_nbits;
    logic [3:0]               r_bit_cnt;
    logic                     r_par_en;
    logic                     r_par_odd;
    logic                     r_two_stop;
    logic                     r_stop_cnt;
    logic                     r_par_flag;
    logic [DATA_WIDTH-1:0]    r_shift;
    logic [OSW:0]             r_high_cnt;

    logic [DIVIDER_WIDTH-1:0] w_div_top;
    logic                     w_tick;
    logic                     w_start_edge;
    logic                     w_mid;
    logic                     w_bit;
    logic                     w_cfg_ok;
    logic                     w_par_exp;
    logic                     w_deliver;

    assign w_div_top = (clk_divider_i <= DIVIDER_WIDTH'(1)) ? '0
                     : clk_divider_i - DIVIDER_WIDTH'(1);
    assign w_tick       = (r_div_cnt >= w_div_top);
    assign w_start_edge = (r_state == S_IDLE) && r_rx_prev && !r_rx_s2;
    assign w_cfg_ok     = (data_bits_i >= 4'd5) && (data_bits_i <= NB_MAX);
    assign w_par_exp    = r_par_odd ? ~^r_shift : ^r_shift;

`ifdef UART_RX_MAJORITY_EN
    logic r_maj_a;
    logic r_maj_b;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_maj_a <= 1'b1;
            r_maj_b <= 1'b1;
        end else if (w_tick) begin
            if (r_os_cnt == OS_PRE[OSW-1:0]) r_maj_a <= r_rx_s2;
            if (r_os_cnt == OS_MID[OSW-1:0]) r_maj_b <= r_rx_s2;
        end
    end

    assign w_mid = w_tick && (r_os_cnt == OS_POST[OSW-1:0]);
    assign w_bit = (r_maj_a & r_maj_b) | (r_maj_a & r_rx_s2)
                 | (r_maj_b & r_rx_s2);
`else
    assign w_mid = w_tick && (r_os_cnt == OS_MID[OSW-1:0]);
    assign w_bit = r_rx_s2;
`endif

    assign w_deliver = w_mid && (r_state == S_STOP) && w_bit
                     && (!r_two_stop || r_stop_cnt);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rx_s1      <= 1'b1;
            r_rx_s2      <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_div_cnt    <= '0;
            r_os_cnt     <= '0;
            r_state      <= S_IDLE;
            r_nbits      <= '0;
            r_bit_cnt    <= '0;
            r_par_en     <= 1'b0;
            r_par_odd    <= 1'b0;
            r_two_stop   <= 1'b0;
            r_stop_cnt   <= 1'b0;
            r_par_flag   <= 1'b0;
            r_shift      <= '0;
            r_high_cnt   <= '0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            r_rx_s1      <= uart_rx_i;
            r_rx_s2      <= r_rx_s1;
            r_rx_prev    <= r_rx_s2;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= w_deliver && m_axis_tvalid_o && !m_axis_tready_i;

            // Bit timing is re-phased to the start edge.
            if (w_start_edge) begin
                r_div_cnt <= '0;
                r_os_cnt  <= '0;
            end else if (w_tick) begin
                r_div_cnt <= '0;
                r_os_cnt  <= (r_os_cnt == OS_LAST[OSW-1:0]) ? '0
                           : r_os_cnt + 1'b1;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end

            unique case (r_state)
                S_IDLE: begin
                    if (w_start_edge) begin
                        r_state    <= S_START;
                        r_nbits    <= w_cfg_ok ? data_bits_i : NB_MAX;
                        r_par_en   <= parity_odd_i | parity_even_i;
                        r_par_odd  <= parity_odd_i;
                        r_two_stop <= two_stop_i;
                        r_shift    <= '0;
                        r_bit_cnt  <= '0;
                        r_stop_cnt <= 1'b0;
                        r_par_flag <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_mid) r_state <= w_bit ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (w_mid) begin
                        for (int i = 0; i < DATA_WIDTH; i++) begin
                            if (r_bit_cnt == i[3:0]) r_shift[i] <= w_bit;
                        end
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == r_nbits - 4'd1) begin
                            r_state <= r_par_en ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_mid) begin
                        r_par_flag <= (w_bit != w_par_exp);
                        r_state    <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_mid) begin
                        if (!w_bit) begin
                            frame_err_o <= 1'b1;
                            r_high_cnt  <= '0;
                            r_state     <= S_WAIT;
                        end else if (r_two_stop && !r_stop_cnt) begin
                            r_stop_cnt <= 1'b1;
                        end else begin
                            parity_err_o <= r_par_flag;
                            r_state      <= S_IDLE;
                        end
                    end
                end
                S_WAIT: begin
                    // Leave only after a full bit time of idle-high line.
                    if (w_tick) begin
                        if (!r_rx_s2) begin
                            r_high_cnt <= '0;
                        end else if (r_high_cnt == OS_LAST[OSW:0]) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_high_cnt <= r_high_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A delivery during a handshake replaces the word without overrun.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_axis_tdata_o  <= '0;
            m_axis_tvalid_o <= 1'b0;
        end else if (w_deliver && !(m_axis_tvalid_o && !m_axis_tready_i)) begin
            m_axis_tdata_o  <= r_shift;
            m_axis_tvalid_o <= 1'b1;
        end else if (m_axis_tvalid_o && m_axis_tready_i) begin
            m_axis_tvalid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_uart_rx_os.sv
// Directed self-checking bench for axis_uart_rx_os.
// Frames are hand-built bit vectors sent LSB first.
module tb_axis_uart_rx_os;
    localparam int DW = 8;
    localparam int OS = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   div = 32'd1;
    logic [3:0]    dbits = 4'd8;
    logic          podd = 1'b0;
    logic          peven = 1'b0;
    logic          two_stop = 1'b0;
    logic          rx = 1'b1;
    logic          tready = 1'b1;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          perr;
    logic          ferr;
    logic          ovr;

    int n_checks = 0;
    int n_fail = 0;
    int bit_cyc = OS;
    logic [DW-1:0] q[$];
    int n_vcyc = 0;
    int n_perr = 0;
    int n_perr_dlv = 0;
    int n_ferr = 0;
    int n_ovr = 0;
    logic [DW-1:0] got;

    always #5 clk = ~clk;

    axis_uart_rx_os #(
        .DATA_WIDTH(DW),
        .DIVIDER_WIDTH(32),
        .OVERSAMPLE(OS)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .clk_divider_i(div),
        .data_bits_i(dbits),
        .parity_odd_i(podd),
        .parity_even_i(peven),
        .two_stop_i(two_stop),
        .uart_rx_i(rx),
        .m_axis_tdata_o(tdata),
        .m_axis_tvalid_o(tvalid),
        .m_axis_tready_i(tready),
        .parity_err_o(perr),
        .frame_err_o(ferr),
        .overrun_o(ovr)
    );

    always @(negedge clk) begin
        if (tvalid && tready) q.push_back(tdata);
        if (tvalid) n_vcyc++;
        if (perr) begin
            n_perr++;
            if (tvalid) n_perr_dlv++;
        end
        if (ferr) n_ferr++;
        if (ovr) n_ovr++;
    end

    task automatic clear_mon();
        q.delete();
        n_vcyc = 0;
        n_perr = 0;
        n_perr_dlv = 0;
        n_ferr = 0;
        n_ovr = 0;
    endtask

    task automatic send_raw(input logic [31:0] bits, input int n);
        logic [31:0] b;
        b = bits;
        for (int i = 0; i < n; i++) begin
            rx = b[0];
            b = b >> 1;
            repeat (bit_cyc) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int nbits);
        rx = 1'b1;
        repeat (nbits * bit_cyc) @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] head();
        return (q.size() > 0) ? q[0] : 'x;
    endfunction

    task automatic test_reset();
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tvalid: got %b want 0", tvalid);
        end
        n_checks++;
        if (tdata !== '0) begin
            n_fail++;
            $display("FAIL reset_tdata: got %h want 00", tdata);
        end
        n_checks++;
        if ({perr, ferr, ovr} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_errs: got %b want 000", {perr, ferr, ovr});
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_basic();
        logic [7:0] vec [4];
        vec = '{8'hA5, 8'h00, 8'hFF, 8'h81};
        for (int k = 0; k < 4; k++) begin
            clear_mon();
            send_raw({22'h0, 1'b1, vec[k], 1'b0}, 10);
            idle(2);
            got = head();
            n_checks++;
            if (q.size() !== 1 || got !== vec[k]) begin
                n_fail++;
                $display("FAIL basic_%0d: got %0d words, %h want 1 word %h",
                         k, q.size(), got, vec[k]);
            end
            n_checks++;
            if (n_vcyc !== 1) begin
                n_fail++;
                $display("FAIL basic_vcyc_%0d: got %0d want 1", k, n_vcyc);
            end
            n_checks++;
            if (n_perr + n_ferr + n_ovr !== 0) begin
                n_fail++;
                $display("FAIL basic_err_%0d: got %0d want 0",
                         k, n_perr + n_ferr + n_ovr);
            end
        end
    endtask

    task automatic test_parity();
        // 0x55 in 7 bits has four ones: odd parity bit is 1.
        dbits = 4'd7;
        podd = 1'b1;
        clear_mon();
        send_raw({22'h0, 1'b1, 1'b1, 7'h55, 1'b0}, 10);
        idle(2);
        got = head();
        n_checks++;
        if (got !== 8'h55 || n_perr !== 0) begin
            n_fail++;
            $display("FAIL par_odd_ok: got %h perr=%0d want 55 perr=0",
                     got, n_perr);
        end
        clear_mon();
        send_raw({22'h0, 1'b1, 1'b0, 7'h55, 1'b0}, 10);
        idle(2);
        got = head();
        n_checks++;
        if (got !== 8'h55 || n_perr !== 1 || n_perr_dlv !== 1) begin
            n_fail++;
            $display("FAIL par_odd_bad: got %h perr=%0d dlv=%0d want 55 1 1",
                     got, n_perr, n_perr_dlv);
        end
        // Odd wins over even: 0x03 -> odd bit 1.
        dbits = 4'd8;
        peven = 1'b1;
        clear_mon();
        send_raw({21'h0, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
        idle(2);
        got = head();
        n_checks++;
        if (got !== 8'h03 || n_perr !== 0) begin
            n_fail++;
            $display("FAIL par_prio: got %h perr=%0d want 03 perr=0",
                     got, n_perr);
        end
        podd = 1'b0;
        clear_mon();
        send_raw({21'h0, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
        idle(2);
        got = head();
        n_checks++;
        if (got !== 8'h03 || n_perr !== 1) begin
            n_fail++;
            $display("FAIL par_even_bad: got %h perr=%0d want 03 perr=1",
                     got, n_perr);
        end
        peven = 1'b0;
    endtask

    task automatic test_frame_err();
        two_stop = 1'b1;
        clear_mon();
        send_raw({21'h0, 1'b0, 1'b1, 8'h96, 1'b0}, 11);
        rx = 1'b0;
        repeat (40 * bit_cyc) @(posedge clk);
        #1;
        idle(2);
        n_checks++;
        if (n_ferr !== 1 || n_vcyc !== 0 || n_perr + n_ovr !== 0) begin
            n_fail++;
            $display("FAIL frame_err: got ferr=%0d vcyc=%0d want 1 0",
                     n_ferr, n_vcyc);
        end
        clear_mon();
        send_raw({21'h0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11);
        idle(2);
        got = head();
        n_checks++;
        if (q.size() !== 1 || got !== 8'h3C || n_ferr !== 0) begin
            n_fail++;
            $display("FAIL frame_recover: got %h ferr=%0d want 3C ferr=0",
                     got, n_ferr);
        end
        two_stop = 1'b0;
    endtask

    task automatic test_overrun();
        tready = 1'b0;
        clear_mon();
        send_raw({22'h0, 1'b1, 8'h11, 1'b0}, 10);
        idle(2);
        send_raw({22'h0, 1'b1, 8'h22, 1'b0}, 10);
        idle(2);
        n_checks++;
        if (tvalid !== 1'b1 || tdata !== 8'h11) begin
            n_fail++;
            $display("FAIL ovr_hold: got v=%b %h want v=1 11", tvalid, tdata);
        end
        n_checks++;
        if (n_ovr !== 1) begin
            n_fail++;
            $display("FAIL ovr_pulse: got %0d want 1", n_ovr);
        end
        tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        got = head();
        n_checks++;
        if (q.size() !== 1 || got !== 8'h11 || tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_drain: got %0d words %h v=%b want 1 11 v=0",
                     q.size(), got, tvalid);
        end
    endtask

    task automatic test_glitch();
        clear_mon();
        rx = 1'b0;
        repeat (OS / 4) @(posedge clk);
        #1;
        idle(3);
        n_checks++;
        if (n_vcyc + n_perr + n_ferr + n_ovr !== 0) begin
            n_fail++;
            $display("FAIL glitch: got v=%0d e=%0d want 0 0",
                     n_vcyc, n_perr + n_ferr + n_ovr);
        end
        send_raw({22'h0, 1'b1, 8'h5C, 1'b0}, 10);
        idle(2);
        got = head();
        n_checks++;
        if (q.size() !== 1 || got !== 8'h5C) begin
            n_fail++;
            $display("FAIL glitch_next: got %h want 5C", got);
        end
    endtask

    task automatic test_reset_mid();
        tready = 1'b0;
        clear_mon();
        send_raw({22'h0, 1'b1, 8'h5A, 1'b0}, 10);
        idle(2);
        n_checks++;
        if (tvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: got v=%b want 1", tvalid);
        end
        // Start bit and data bits 0..2 of 0xF0, then reset in bit 3.
        send_raw(32'h0, 4);
        rx = 1'b0;
        repeat (bit_cyc / 2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rx = 1'b1;
        rst = 1'b0;
        n_checks++;
        if (tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_tvalid: got %b want 0", tvalid);
        end
        tready = 1'b1;
        clear_mon();
        idle(3);
        n_checks++;
        if (n_vcyc + n_ferr + n_perr !== 0) begin
            n_fail++;
            $display("FAIL rstmid_quiet: got %0d want 0",
                     n_vcyc + n_ferr + n_perr);
        end
        send_raw({22'h0, 1'b1, 8'h0F, 1'b0}, 10);
        idle(2);
        got = head();
        n_checks++;
        if (q.size() !== 1 || got !== 8'h0F) begin
            n_fail++;
            $display("FAIL rstmid_next: got %h want 0F", got);
        end
    endtask

    task automatic test_divider();
        div = 32'd3;
        bit_cyc = 3 * OS;
        dbits = 4'd4;
        clear_mon();
        send_raw({22'h0, 1'b1, 8'h6B, 1'b0}, 10);
        idle(2);
        got = head();
        n_checks++;
        if (q.size() !== 1 || got !== 8'h6B) begin
            n_fail++;
            $display("FAIL div3_bits4: got %h want 6B", got);
        end
        div = 32'd0;
        bit_cyc = OS;
        dbits = 4'd5;
        idle(1);
        clear_mon();
        send_raw({25'h0, 1'b1, 5'h15, 1'b0}, 7);
        idle(2);
        got = head();
        n_checks++;
        if (q.size() !== 1 || got !== 8'h15) begin
            n_fail++;
            $display("FAIL div0_bits5: got %h want 15", got);
        end
        div = 32'd1;
        dbits = 4'd8;
    endtask

    task automatic test_back_to_back();
        clear_mon();
        send_raw({12'h0, 1'b1, 8'h34, 1'b0, 1'b1, 8'h12, 1'b0}, 20);
        idle(2);
        n_checks++;
        if (q.size() !== 2) begin
            n_fail++;
            $display("FAIL b2b_cnt: got %0d want 2", q.size());
        end else begin
            n_checks++;
            if (q[0] !== 8'h12 || q[1] !== 8'h34) begin
                n_fail++;
                $display("FAIL b2b_data: got %h %h want 12 34", q[0], q[1]);
            end
        end
    endtask

    task automatic test_cfg_latch();
        clear_mon();
        fork
            send_raw({22'h0, 1'b1, 8'hC3, 1'b0}, 10);
            begin
                repeat (3 * OS) @(posedge clk);
                #1;
                dbits = 4'd5;
                podd = 1'b1;
                two_stop = 1'b1;
            end
        join
        dbits = 4'd8;
        podd = 1'b0;
        two_stop = 1'b0;
        idle(2);
        got = head();
        n_checks++;
        if (q.size() !== 1 || got !== 8'hC3 || n_perr + n_ferr !== 0) begin
            n_fail++;
            $display("FAIL cfg_latch: got %h errs=%0d want C3 0",
                     got, n_perr + n_ferr);
        end
    endtask

`ifdef UART_RX_MAJORITY_EN
    task automatic test_majority();
        logic [7:0] d;
        d = 8'hA5;
        clear_mon();
        send_raw(32'h0, 1);
        for (int i = 0; i < 8; i++) begin
            rx = d[0];
            repeat (OS / 2) @(posedge clk);
            #1;
            rx = ~d[0];
            @(posedge clk);
            #1;
            rx = d[0];
            repeat (OS / 2 - 1) @(posedge clk);
            #1;
            d = d >> 1;
        end
        idle(3);
        got = head();
        n_checks++;
        if (q.size() !== 1 || got !== 8'hA5) begin
            n_fail++;
            $display("FAIL majority: got %h want A5", got);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_frame_err();
        test_overrun();
        test_glitch();
        test_reset_mid();
        test_divider();
        test_back_to_back();
        test_cfg_latch();
`ifdef UART_RX_MAJORITY_EN
        test_majority();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
